// File: rtl/ddram_mc_pkg.sv
// Shared types and helpers for the DDRAM burst memory controller.
package ddram_mc_pkg;

  localparam int unsigned BEAT_W = 64;

  typedef enum logic [1:0] {StIdle, StWr, StRd, StBeat} mc_state_e;

  // Zero beats means one beat; anything above the line buffer size is clipped to it.
  function automatic logic [7:0] clip_burst(input logic [7:0] burst, input int unsigned max_burst);
    if (burst == 8'd0) return 8'd1;
    if (32'(burst) > max_burst) return 8'(max_burst);
    return burst;
  endfunction

endpackage

// File: rtl/ddram_req_latch.sv
// Rising-edge request capture: holds a pending flag with its operands and reports dropped edges.
module ddram_req_latch #(
  parameter int unsigned OpW = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_i,
  input  logic           clr_i,
  input  logic [OpW-1:0] op_i,
  output logic           pend_o,
  output logic [OpW-1:0] op_o,
  output logic           overrun_o
);

  logic           req_q, pend_q, ovr_q;
  logic           req_d, pend_d, ovr_d;
  logic [OpW-1:0] op_q, op_d;
  logic           req_edge;

  assign req_edge = req_i & ~req_q;

  // An edge that arrives while the previous request is still owed is dropped, not queued.
  always_comb begin
    req_d  = req_i;
    ovr_d  = req_edge & pend_q;
    pend_d = pend_q;
    op_d   = op_q;
    if (clr_i) pend_d = 1'b0;
    if (req_edge && !pend_q) begin
      pend_d = 1'b1;
      op_d   = op_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      op_q   <= '0;
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      op_q   <= op_d;
    end
  end

  assign pend_o    = pend_q;
  assign op_o      = op_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/ddram_burst_mc.sv
// DDRAM master serving byte-enabled single writes and burst reads into NCH line buffers.
// Optional read watchdog: define DDRAM_RD_TIMEOUT_EN.
module ddram_burst_mc
  import ddram_mc_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned CHW       = 1,
  parameter int unsigned MAX_BURST = 15,
  parameter logic [3:0]  BASE_NIB  = 4'b0011
) (
  input  logic                        DDRAM_CLK,
  input  logic                        DDRAM_RESET_N,
  input  logic                        DDRAM_BUSY,
  output logic [7:0]                  DDRAM_BURSTCNT,
  output logic [28:0]                 DDRAM_ADDR,
  input  logic [63:0]                 DDRAM_DOUT,
  input  logic                        DDRAM_DOUT_READY,
  output logic                        DDRAM_RD,
  output logic [63:0]                 DDRAM_DIN,
  output logic [7:0]                  DDRAM_BE,
  output logic                        DDRAM_WE,
  input  logic [24:0]                 mem_addr,
  input  logic [63:0]                 mem_din,
  input  logic [7:0]                  mem_be,
  input  logic                        mem_wr,
  input  logic                        mem_rd,
  input  logic [CHW-1:0]              mem_rd_ch,
  input  logic [7:0]                  mem_burst,
  input  logic [CHW-1:0]              mem_dout_ch,
  output logic [63:0]                 mem_dout,
  output logic [64*MAX_BURST-1:0]     mem_wide_dout,
  output logic                        mem_busy,
  output logic                        mem_dready,
  output logic                        mem_overrun,
  output logic                        mem_timeout
);

  localparam int unsigned WrOpW = 25 + 64 + 8;
  localparam int unsigned RdOpW = 25 + CHW + 8;
  localparam int unsigned BiW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic             wr_pend, rd_pend, wr_ovr, rd_ovr, wr_clr, rd_clr;
  logic [WrOpW-1:0] wr_op;
  logic [RdOpW-1:0] rd_op;
  logic [24:0]      wr_addr, rd_addr;
  logic [63:0]      wr_din;
  logic [7:0]       wr_be, rd_burst;
  logic [CHW-1:0]   rd_ch;
  logic             last_beat, timeout_hit;

  mc_state_e        state_q;
  logic [7:0]       beat_q, bc_q, be_q;
  logic             we_q, rd_q, dready_q, last_wr_q;
  logic [28:0]      addr_q;
  logic [63:0]      din_q, dout_q;
  logic [MAX_BURST-1:0][BEAT_W-1:0] buf_q [NCH];

  ddram_req_latch #(.OpW(WrOpW)) u_wr_latch (
    .clk_i    (DDRAM_CLK),
    .rst_ni   (DDRAM_RESET_N),
    .req_i    (mem_wr),
    .clr_i    (wr_clr),
    .op_i     ({mem_addr, mem_din, mem_be}),
    .pend_o   (wr_pend),
    .op_o     (wr_op),
    .overrun_o(wr_ovr)
  );

  // The burst is clipped at capture so the stored length is always a legal beat count.
  ddram_req_latch #(.OpW(RdOpW)) u_rd_latch (
    .clk_i    (DDRAM_CLK),
    .rst_ni   (DDRAM_RESET_N),
    .req_i    (mem_rd),
    .clr_i    (rd_clr),
    .op_i     ({mem_addr, mem_rd_ch, clip_burst(mem_burst, MAX_BURST)}),
    .pend_o   (rd_pend),
    .op_o     (rd_op),
    .overrun_o(rd_ovr)
  );

  assign {wr_addr, wr_din, wr_be}   = wr_op;
  assign {rd_addr, rd_ch, rd_burst} = rd_op;

  assign wr_clr    = (state_q == StWr) && !DDRAM_BUSY;
  assign last_beat = (state_q == StBeat) && DDRAM_DOUT_READY && (beat_q == rd_burst - 8'd1);
  assign rd_clr    = last_beat | timeout_hit;

`ifdef DDRAM_RD_TIMEOUT_EN
  logic [11:0] wd_q;
  logic        timeout_q;

  assign timeout_hit = (state_q == StBeat) && !DDRAM_DOUT_READY && (wd_q == 12'd4094);

  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state_q != StBeat || DDRAM_DOUT_READY || timeout_hit) wd_q <= '0;
      else wd_q <= wd_q + 12'd1;
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      be_q      <= 8'hFF;
      bc_q      <= 8'd1;
      dready_q  <= 1'b0;
      dout_q    <= '0;
      last_wr_q <= 1'b0;
      for (int i = 0; i < NCH; i++) buf_q[i] <= '0;
    end else begin
      dready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // last_wr_q only moves when both requests compete, so the loser goes next time.
          if (!DDRAM_BUSY) begin
            if (wr_pend && (!rd_pend || !last_wr_q)) begin
              state_q <= StWr;
              we_q    <= 1'b1;
              addr_q  <= {BASE_NIB, wr_addr};
              din_q   <= wr_din;
              be_q    <= wr_be;
              bc_q    <= 8'd1;
              if (rd_pend) last_wr_q <= 1'b1;
            end else if (rd_pend) begin
              state_q <= StRd;
              rd_q    <= 1'b1;
              addr_q  <= {BASE_NIB, rd_addr};
              be_q    <= 8'hFF;
              bc_q    <= rd_burst;
              if (wr_pend) last_wr_q <= 1'b0;
            end
          end
        end
        StWr: begin
          if (!DDRAM_BUSY) begin
            we_q    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRd: begin
          if (!DDRAM_BUSY) begin
            rd_q    <= 1'b0;
            beat_q  <= '0;
            state_q <= StBeat;
          end
        end
        StBeat: begin
          if (DDRAM_DOUT_READY) begin
            buf_q[rd_ch][beat_q[BiW-1:0]] <= DDRAM_DOUT;
            if (beat_q == 8'd0) dout_q <= DDRAM_DOUT;
            beat_q <= beat_q + 8'd1;
            if (last_beat) begin
              dready_q <= 1'b1;
              state_q  <= StIdle;
            end
          end else if (timeout_hit) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DDRAM_WE       = we_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_BURSTCNT = bc_q;
  assign mem_dout       = dout_q;
  assign mem_dready     = dready_q;
  assign mem_overrun    = wr_ovr | rd_ovr;
  assign mem_busy       = wr_pend | rd_pend;
  assign mem_wide_dout  = buf_q[mem_dout_ch];

endmodule

// File: tb/tb_ddram_burst_mc.sv
// Bench for ddram_burst_mc: directed scenarios plus random traffic against a transaction model.
module tb_ddram_burst_mc;

  localparam int MB = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy = 1'b0, dout_ready = 1'b0;
  logic [7:0]      burstcnt, be_o;
  logic [28:0]     addr_o;
  logic [63:0]     dout = '0, din_o;
  logic            rd_o, we_o;
  logic [24:0]     mem_addr = '0;
  logic [63:0]     mem_din = '0;
  logic [7:0]      mem_be = '0, mem_burst = '0;
  logic            mem_wr = 1'b0, mem_rd = 1'b0;
  logic [0:0]      mem_rd_ch = '0, mem_dout_ch = '0;
  logic [63:0]     mem_dout;
  logic [64*MB-1:0] mem_wide_dout;
  logic            mem_busy, mem_dready, mem_overrun, mem_timeout;

  ddram_burst_mc dut (
    .DDRAM_CLK       (clk),
    .DDRAM_RESET_N   (rst_n),
    .DDRAM_BUSY      (busy),
    .DDRAM_BURSTCNT  (burstcnt),
    .DDRAM_ADDR      (addr_o),
    .DDRAM_DOUT      (dout),
    .DDRAM_DOUT_READY(dout_ready),
    .DDRAM_RD        (rd_o),
    .DDRAM_DIN       (din_o),
    .DDRAM_BE        (be_o),
    .DDRAM_WE        (we_o),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_be          (mem_be),
    .mem_wr          (mem_wr),
    .mem_rd          (mem_rd),
    .mem_rd_ch       (mem_rd_ch),
    .mem_burst       (mem_burst),
    .mem_dout_ch     (mem_dout_ch),
    .mem_dout        (mem_dout),
    .mem_wide_dout   (mem_wide_dout),
    .mem_busy        (mem_busy),
    .mem_dready      (mem_dready),
    .mem_overrun     (mem_overrun),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Transaction model: 0 idle, 1 write command on bus, 2 read command on bus, 3 collecting beats.
  int          m_mode, m_beat, m_rch, m_rbur, busy_left;
  bit          m_wp, m_rp, m_last_wr, m_prev_wr, m_prev_rd;
  logic [24:0] m_waddr, m_raddr;
  logic [63:0] m_wdin, m_dout;
  logic [7:0]  m_wbe;
  logic [63:0] m_buf [2][MB];
  bit          e_we, e_rd, e_dready, e_ovr;
  logic [28:0] e_addr;
  logic [63:0] e_din;
  logic [7:0]  e_be, e_bc;

  bit rand_busy = 1'b1, fixed_data = 1'b0;
  int fixed_busy = 0;

  // Observations of the DUT bus for the directed literal checks.
  bit          p_we, p_rd;
  int          obs_kind[$];
  logic [28:0] obs_waddr;
  logic [63:0] obs_wdin;
  logic [7:0]  obs_wbe, obs_wbc, obs_rbc;
  int          rd_high, dready_cnt, ovr_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int clip(input int b);
    if (b == 0) return 1;
    if (b > MB) return MB;
    return b;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_beat = 0; m_wp = 0; m_rp = 0; m_last_wr = 0; m_prev_wr = 0; m_prev_rd = 0;
    m_dout = '0; busy_left = 0;
    for (int c = 0; c < 2; c++) for (int k = 0; k < MB; k++) m_buf[c][k] = '0;
    e_we = 0; e_rd = 0; e_dready = 0; e_ovr = 0; e_addr = '0; e_din = '0; e_be = 8'hFF; e_bc = 8'd1;
  endtask

  task automatic clear_obs();
    obs_kind.delete(); rd_high = 0; dready_cnt = 0; ovr_cnt = 0;
  endtask

  task automatic start_cmd();
    busy_left = rand_busy ? int'($urandom_range(0, 3)) : fixed_busy;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit clr_w = 0, clr_r = 0, old_wp = m_wp, old_rp = m_rp;
    e_dready = 0; e_ovr = 0;
    case (m_mode)
      0: if (!busy) begin
        if (m_wp && (!m_rp || !m_last_wr)) begin
          m_mode = 1; e_we = 1; e_addr = {4'h3, m_waddr}; e_din = m_wdin; e_be = m_wbe; e_bc = 8'd1;
          if (m_rp) m_last_wr = 1;
          start_cmd();
        end else if (m_rp) begin
          m_mode = 2; e_rd = 1; e_addr = {4'h3, m_raddr}; e_be = 8'hFF; e_bc = 8'(m_rbur);
          if (m_wp) m_last_wr = 0;
          start_cmd();
        end
      end
      1: if (!busy) begin e_we = 0; clr_w = 1; m_mode = 0; end
      2: if (!busy) begin e_rd = 0; m_mode = 3; m_beat = 0; end
      default: if (dout_ready) begin
        m_buf[m_rch][m_beat] = dout;
        if (m_beat == 0) m_dout = dout;
        m_beat++;
        if (m_beat == m_rbur) begin m_mode = 0; e_dready = 1; clr_r = 1; end
      end
    endcase
    if (clr_w) m_wp = 0;
    if (clr_r) m_rp = 0;
    if (mem_wr && !m_prev_wr) begin
      if (old_wp) e_ovr = 1;
      else begin m_wp = 1; m_waddr = mem_addr; m_wdin = mem_din; m_wbe = mem_be; end
    end
    if (mem_rd && !m_prev_rd) begin
      if (old_rp) e_ovr = 1;
      else begin m_rp = 1; m_raddr = mem_addr; m_rch = int'(mem_rd_ch); m_rbur = clip(int'(mem_burst)); end
    end
    m_prev_wr = mem_wr; m_prev_rd = mem_rd;
  endtask

  task automatic compare();
    int bad = -1;
    chk("we", 64'(we_o), 64'(e_we));
    chk("rd", 64'(rd_o), 64'(e_rd));
    chk("busy", 64'(mem_busy), 64'(m_wp | m_rp));
    chk("dready", 64'(mem_dready), 64'(e_dready));
    chk("overrun", 64'(mem_overrun), 64'(e_ovr));
    chk("mem_dout", mem_dout, m_dout);
`ifndef DDRAM_RD_TIMEOUT_EN
    chk("timeout", 64'(mem_timeout), 64'd0);
`endif
    if (e_we || e_rd) begin
      chk("addr", 64'(addr_o), 64'(e_addr));
      chk("be", 64'(be_o), 64'(e_be));
      chk("burstcnt", 64'(burstcnt), 64'(e_bc));
      if (e_we) chk("din", din_o, e_din);
    end
    for (int k = 0; k < MB; k++)
      if (bad < 0 && mem_wide_dout[64*k +: 64] !== m_buf[mem_dout_ch][k]) bad = k;
    n_chk++;
    if (bad < 0) n_pass++;
    else $display("FAIL wide ch%0d beat%0d: got %h expected %h", mem_dout_ch, bad,
                  mem_wide_dout[64*bad +: 64], m_buf[mem_dout_ch][bad]);
    if (we_o && !p_we) begin
      obs_kind.push_back(1); obs_waddr = addr_o; obs_wdin = din_o; obs_wbe = be_o; obs_wbc = burstcnt;
    end
    if (rd_o && !p_rd) begin obs_kind.push_back(2); obs_rbc = burstcnt; end
    if (rd_o) rd_high++;
    if (mem_dready) dready_cnt++;
    if (mem_overrun) ovr_cnt++;
    p_we = we_o; p_rd = rd_o;
  endtask

  task automatic tick();
    if (m_mode == 1 || m_mode == 2) begin
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end else busy = 1'b0;
    if (m_mode == 3) begin
      dout_ready = fixed_data ? 1'b1 : ($urandom_range(0, 2) != 0);
      dout = fixed_data ? (64'hA000_0000_0000_0000 | 64'(m_beat)) : {$urandom, $urandom};
    end else begin
      dout_ready = 1'b0;
      dout = {$urandom, $urandom};
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
    mem_dout_ch = 1'($urandom_range(0, 1));
  endtask

  task automatic scramble_ops();
    mem_addr = 25'($urandom); mem_din = {$urandom, $urandom}; mem_be = 8'($urandom);
    mem_rd_ch = 1'($urandom); mem_burst = 8'($urandom);
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [63:0] d, input logic [7:0] b);
    mem_addr = a; mem_din = d; mem_be = b; mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0; scramble_ops();
  endtask

  task automatic pulse_rd(input logic [24:0] a, input logic [0:0] ch, input logic [7:0] bu);
    mem_addr = a; mem_rd_ch = ch; mem_burst = bu; mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0; scramble_ops();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((m_wp || m_rp || m_mode != 0 || mem_busy) && n < 300) begin tick(); n++; end
    n_chk++;
    if (n < 300) n_pass++;
    else $display("FAIL %s drain: got busy after %0d cycles expected idle", nm, n);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_we"}, 64'(we_o), 64'd0);
    chk({nm, "_rd"}, 64'(rd_o), 64'd0);
    chk({nm, "_be"}, 64'(be_o), 64'hFF);
    chk({nm, "_bc"}, 64'(burstcnt), 64'd1);
    chk({nm, "_addr"}, 64'(addr_o), 64'd0);
    chk({nm, "_busy"}, 64'(mem_busy), 64'd0);
    chk({nm, "_dready"}, 64'(mem_dready), 64'd0);
    chk({nm, "_dout"}, mem_dout, 64'd0);
  endtask

  task automatic release_reset();
    busy = 0; dout_ready = 0; mem_wr = 0; mem_rd = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    p_we = 0; p_rd = 0;
    clear_obs();
    compare();
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("rst");
    release_reset();

    // Single write, no BUSY.
    clear_obs(); rand_busy = 0; fixed_busy = 0;
    pulse_wr(25'h10, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    wait_idle("wr");
    chk("wr_count", 64'(obs_kind.size()), 64'd1);
    chk("wr_addr", 64'(obs_waddr), 64'h0600_0010);
    chk("wr_din", obs_wdin, 64'hDEAD_BEEF_0123_4567);
    chk("wr_be", 64'(obs_wbe), 64'h0F);
    chk("wr_bc", 64'(obs_wbc), 64'd1);
    chk("wr_busy_after", 64'(mem_busy), 64'd0);

    // Read of 4 beats into buffer 1.
    clear_obs(); fixed_data = 1;
    pulse_rd(25'h20, 1'b1, 8'd4);
    wait_idle("rd4");
    chk("rd4_bc", 64'(obs_rbc), 64'd4);
    chk("rd4_dready", 64'(dready_cnt), 64'd1);
    chk("rd4_dout", mem_dout, 64'hA000_0000_0000_0000);
    mem_dout_ch = 1'b1; #1;
    chk("rd4_buf1_b3", mem_wide_dout[64*3 +: 64], 64'hA000_0000_0000_0003);
    mem_dout_ch = 1'b0; #1;
    chk("rd4_buf0_b0", mem_wide_dout[63:0], 64'd0);

    // Simultaneous edges: write first, then read first on the repeat.
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      mem_addr = 25'($urandom); mem_din = {$urandom, $urandom}; mem_be = 8'($urandom);
      mem_rd_ch = 1'b0; mem_burst = 8'd2;
      mem_wr = 1; mem_rd = 1;
      tick();
      mem_wr = 0; mem_rd = 0;
      wait_idle("both");
      chk("both_n", 64'(obs_kind.size()), 64'd2);
      if (obs_kind.size() == 2) chk("both_first", 64'(obs_kind[0]), (r == 0) ? 64'd1 : 64'd2);
    end

    // Burst clipping and retention of untouched buffer regions.
    clear_obs();
    pulse_rd(25'h40, 1'b0, 8'd200);
    wait_idle("b200");
    chk("b200_bc", 64'(obs_rbc), 64'd15);
    mem_dout_ch = 1'b0; #1;
    chk("b200_b14", mem_wide_dout[64*14 +: 64], 64'hA000_0000_0000_000E);
    clear_obs(); fixed_data = 0;
    pulse_rd(25'h41, 1'b0, 8'd0);
    wait_idle("b0");
    chk("b0_bc", 64'(obs_rbc), 64'd1);
    mem_dout_ch = 1'b0; #1;
    chk("b0_keep_b1", mem_wide_dout[64*1 +: 64], 64'hA000_0000_0000_0001);

    // BUSY held 5 cycles on a read, then a second read edge during the beats.
    clear_obs(); fixed_busy = 5;
    pulse_rd(25'h80, 1'b1, 8'd8);
    n = 0;
    while (m_mode != 3 && n < 40) begin tick(); n++; end
    pulse_rd(25'h99, 1'b0, 8'd2);
    wait_idle("busy5");
    chk("busy5_rd_cycles", 64'(rd_high), 64'd6);
    chk("busy5_overrun", 64'(ovr_cnt), 64'd1);
    chk("busy5_dready", 64'(dready_cnt), 64'd1);
    fixed_busy = 0;

    // Reset after two of eight beats, then a normal read.
    clear_obs(); fixed_data = 1;
    pulse_rd(25'h100, 1'b0, 8'd8);
    n = 0;
    while (!(m_mode == 3 && m_beat == 2) && n < 40) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    release_reset();
    pulse_rd(25'h200, 1'b1, 8'd3);
    wait_idle("postrst");
    chk("postrst_dready", 64'(dready_cnt), 64'd1);
    chk("postrst_dout", mem_dout, 64'hA000_0000_0000_0000);
    fixed_data = 0;

    // Random traffic.
    rand_busy = 1;
    for (int i = 0; i < 600; i++) begin
      mem_wr = ($urandom_range(0, 5) == 0);
      mem_rd = ($urandom_range(0, 9) == 0);
      mem_addr = 25'($urandom); mem_din = {$urandom, $urandom}; mem_be = 8'($urandom);
      mem_rd_ch = 1'($urandom);
      mem_burst = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      tick();
    end
    mem_wr = 0; mem_rd = 0;
    wait_idle("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
